alarm_setter: RTL and testbench
===============================

Name: alarm_setter

Overview:
- Upstream user-input stage for the BCD time-of-day clock block.
- Debounces two raw push-buttons and runs the mode state machine that drives the clock's 2-bit `key_b` mode bus.
- Holds the editable alarm time as packed BCD and presents it on `alarm_hour` / `alarm_minute` / `alarm_second` for the clock's alarm comparator.
- Supports held-key auto-repeat and an inactivity timeout back to run mode.

Parameters:
- DEB_CYCLES, 20'd500000: consecutive stable cycles required before a key level change is accepted (min 2).
- REPEAT_DELAY, 24'd10000000: cycles `key_inc` must stay held before auto-repeat starts.
- REPEAT_PERIOD, 24'd2500000: cycles between auto-repeat increments.
- IDLE_TIMEOUT, 28'd250000000: cycles with no accepted key event in a set mode before forcing run mode; 0 disables the timeout.
- RST_HOUR, 8'h07: alarm hour loaded at reset (BCD).
- RST_MINUTE, 8'h00: alarm minute loaded at reset (BCD).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- key_mode  input  1  raw mode button, active-low, asynchronous to clk
- key_inc  input  1  raw increment button, active-low, asynchronous to clk
- key_b  output  2  mode to clock block: 00 run, 01 set hour, 10 set minute, 11 set second
- alarm_hour  output  8  BCD, range 00–23
- alarm_minute  output  8  BCD, range 00–59
- alarm_second  output  8  BCD, range 00–59
- mode_pulse  output  1  one-cycle strobe on each accepted mode press (debug/beeper)

Interface (already decided):
- One clock, `clk`.
- Reset `rst_n` is synchronous and active-low: sampled only on the rising edge of `clk`; the block is reset on any edge where `rst_n`=0.

Behaviour:
- Reset values:
  - key_b=2'b00
  - alarm_hour=RST_HOUR
  - alarm_minute=RST_MINUTE
  - alarm_second=8'h00
  - mode_pulse=0
  - Both debounced levels = released (1).
  - Both synchronisers = 1.
  - All counters = 0.
- Reset mid-operation (mid-debounce, mid-repeat, in a set mode) discards all state and returns to the values above on the next edge.
- Synchroniser: each raw key passes through 2 flops before use.
- Debouncer, one per key:
  - Counter increments while the synced level differs from the debounced level; it clears whenever they are equal.
  - When the counter reaches DEB_CYCLES-1 while still differing, the debounced level flips on that edge and the counter clears.
  - Glitches shorter than DEB_CYCLES are rejected.
  - A press event is the debounced 1→0 transition, lasting one cycle.
  - Latency: a raw falling edge held stable produces the press event DEB_CYCLES+2 cycles later.
- Mode FSM, states RUN(00), SET_H(01), SET_M(10), SET_S(11):
  - A mode press advances RUN→SET_H→SET_M→SET_S→RUN.
  - `key_b` changes, and `mode_pulse` is high, on the edge after the press event.
- Increment events:
  - An inc event is the `key_inc` press event, or an auto-repeat tick.
  - In SET_H, SET_M or SET_S it increments the selected field one cycle after the event.
  - In RUN, inc events are ignored.
- Auto-repeat:
  - Active while debounced `key_inc`=0 and the FSM is not RUN.
  - First tick REPEAT_DELAY cycles after the press event, then one tick every REPEAT_PERIOD cycles.
  - Release, a mode change, or entry to RUN clears the repeat counter.
- BCD arithmetic:
  - Low nibble 9 → low nibble 0 and high nibble +1.
  - Hour 8'h23 → 8'h00. Minute/second 8'h59 → 8'h00.
  - Fields never hold non-BCD values or values outside their range.
- Simultaneous mode press and inc event in the same cycle: mode press wins; the inc is dropped.
- Timeout:
  - Idle counter clears on any accepted press or repeat tick and on entry to a set mode.
  - It counts only while not in RUN.
  - When it reaches IDLE_TIMEOUT-1, key_b goes to 00 on the next edge; `mode_pulse` stays 0.
  - Alarm values are retained.
  - IDLE_TIMEOUT=0 means the counter never forces RUN.
- Outputs are registered; no combinational path from the raw keys to any output.

Test Plan (DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, IDLE_TIMEOUT=100):
- Reset, then hold `rst_n`=0 for 3 cycles → key_b=00, alarm=07:00:00, mode_pulse=0. Repeat the reset while in SET_M with a repeat in progress → same values.
- `key_mode` low 3 cycles, then high → no mode change. Held low 10 cycles → key_b=01 exactly 7 cycles after the falling edge, and mode_pulse high that one cycle only.
- In SET_H with hour=8'h22, press inc twice (each held 6 cycles, released 6) → 23, then 00. In SET_M from 8'h09, press once → 8'h10. In SET_S from 8'h59, press once → 8'h00.
- In SET_M with minute=8'h00, hold `key_inc` 50 cycles → increments at press+1 (01), press+21 (02), press+26, +31, +36, +41, +46 (07). Release → no further change.
- Mode and inc presses aligned to the same press cycle in SET_H → key_b=10, hour unchanged.
- Enter SET_S, no keys for 100 cycles → key_b returns to 00, alarm values unchanged. In RUN, an inc press → no field changes.

Source files
------------

// File: rtl/alarm_setter.sv
// Alarm setter: user-input front end for the BCD time-of-day clock.
//
// Debounces two raw active-low push-buttons, steps the set-mode state machine
// (run / set hour / set minute / set second) and holds the editable alarm time
// as packed BCD. A held increment key auto-repeats, and an idle timeout drops
// back to run mode.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   key_mode     raw mode button, active-low, asynchronous to clk
//   key_inc      raw increment button, active-low, asynchronous to clk
//   key_b        mode to clock block: 00 run, 01 set hour, 10 set minute, 11 set second
//   alarm_hour   alarm hour, BCD 00-23
//   alarm_minute alarm minute, BCD 00-59
//   alarm_second alarm second, BCD 00-59
//   mode_pulse   one-cycle strobe on each accepted mode press
module alarm_setter #(
   parameter logic [19:0] DEB_CYCLES    = 20'd500000,
   parameter logic [23:0] REPEAT_DELAY  = 24'd10000000,
   parameter logic [23:0] REPEAT_PERIOD = 24'd2500000,
   parameter logic [27:0] IDLE_TIMEOUT  = 28'd250000000,
   parameter logic [7:0]  RST_HOUR      = 8'h07,
   parameter logic [7:0]  RST_MINUTE    = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic [1:0] key_b,
   output logic [7:0] alarm_hour,
   output logic [7:0] alarm_minute,
   output logic [7:0] alarm_second,
   output logic       mode_pulse
);

   typedef enum logic [1:0] {
      StRun  = 2'b00,
      StSetH = 2'b01,
      StSetM = 2'b10,
      StSetS = 2'b11
   } mode_e;

   // Bit 0 carries the mode key, bit 1 the increment key.
   logic [1:0]  sync1_q, sync1_d;
   logic [1:0]  sync2_q, sync2_d;
   logic [1:0]  deb_q, deb_d;
   logic [1:0]  press_q, press_d;
   logic [19:0] deb_mode_cnt_q, deb_mode_cnt_d;
   logic [19:0] deb_inc_cnt_q, deb_inc_cnt_d;

   logic [23:0] rep_cnt_q, rep_cnt_d;
   logic        rep_run_q, rep_run_d;
   logic [27:0] idle_cnt_q, idle_cnt_d;

   mode_e       state_q, state_d;
   logic [7:0]  hour_q, hour_d;
   logic [7:0]  minute_q, minute_d;
   logic [7:0]  second_q, second_d;
   logic        mode_pulse_q, mode_pulse_d;

   logic        mode_press, inc_press;
   logic        rep_active, rep_tick, inc_evt, any_evt, timeout;

   // One debounce step: returns {next level, next count}. The level only
   // follows the synced input after DEB_CYCLES consecutive differing samples.
   function automatic logic [20:0] deb_next(input logic sync, input logic lvl,
                                            input logic [19:0] cnt);
      logic        lvl_n;
      logic [19:0] cnt_n;
      lvl_n = lvl;
      cnt_n = 20'd0;
      if (sync != lvl) begin
         if (cnt >= DEB_CYCLES - 20'd1) begin
            lvl_n = sync;
         end else begin
            cnt_n = cnt + 20'd1;
         end
      end
      return {lvl_n, cnt_n};
   endfunction

   // BCD increment with wrap at `top`; values at or above `top` wrap to 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] top);
      logic [7:0] res;
      if (val >= top) begin
         res = 8'h00;
      end else if (val[3:0] >= 4'd9) begin
         res = {val[7:4] + 4'd1, 4'd0};
      end else begin
         res = {val[7:4], val[3:0] + 4'd1};
      end
      return res;
   endfunction

   // Synchronisers, debouncers and press detection.
   always_comb begin
      sync1_d = {key_inc, key_mode};
      sync2_d = sync1_q;
      {deb_d[0], deb_mode_cnt_d} = deb_next(sync2_q[0], deb_q[0], deb_mode_cnt_q);
      {deb_d[1], deb_inc_cnt_d}  = deb_next(sync2_q[1], deb_q[1], deb_inc_cnt_q);
      // Registered 1->0 edge of the debounced level.
      press_d = deb_q & ~deb_d;
   end

   assign mode_press = press_q[0];
   assign inc_press  = press_q[1];

   // Auto-repeat: first tick REPEAT_DELAY cycles after the press, then every
   // REPEAT_PERIOD. rep_run_q marks that the initial delay has elapsed.
   always_comb begin
      rep_active = (deb_q[1] == 1'b0) && (state_q != StRun);
      rep_tick   = rep_active &&
                   (rep_run_q ? (rep_cnt_q == REPEAT_PERIOD) : (rep_cnt_q == REPEAT_DELAY));
      inc_evt    = inc_press | rep_tick;
      any_evt    = mode_press | inc_press | rep_tick;
      timeout    = (IDLE_TIMEOUT != 28'd0) && (state_q != StRun) && !any_evt &&
                   (idle_cnt_q == IDLE_TIMEOUT - 28'd1);

      rep_cnt_d = rep_cnt_q + 24'd1;
      rep_run_d = rep_run_q;
      if (!rep_active || mode_press || timeout) begin
         rep_cnt_d = 24'd0;
         rep_run_d = 1'b0;
      end else if (rep_tick) begin
         rep_cnt_d = 24'd1;
         rep_run_d = 1'b1;
      end

      // Only counts in a set mode; any key activity restarts it.
      idle_cnt_d = idle_cnt_q + 28'd1;
      if (IDLE_TIMEOUT == 28'd0 || state_q == StRun || any_evt || timeout) begin
         idle_cnt_d = 28'd0;
      end
   end

   // Mode FSM and alarm field update. A mode press takes priority over a
   // coincident increment, which is dropped.
   always_comb begin
      state_d      = state_q;
      hour_d       = hour_q;
      minute_d     = minute_q;
      second_d     = second_q;
      mode_pulse_d = 1'b0;
      if (mode_press) begin
         mode_pulse_d = 1'b1;
         unique case (state_q)
            StRun:  state_d = StSetH;
            StSetH: state_d = StSetM;
            StSetM: state_d = StSetS;
            StSetS: state_d = StRun;
            default: state_d = StRun;
         endcase
      end else if (timeout) begin
         state_d = StRun;
      end else if (inc_evt) begin
         unique case (state_q)
            StSetH: hour_d   = bcd_inc(hour_q, 8'h23);
            StSetM: minute_d = bcd_inc(minute_q, 8'h59);
            StSetS: second_d = bcd_inc(second_q, 8'h59);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q        <= 2'b11;
         sync2_q        <= 2'b11;
         deb_q          <= 2'b11;
         press_q        <= 2'b00;
         deb_mode_cnt_q <= 20'd0;
         deb_inc_cnt_q  <= 20'd0;
         rep_cnt_q      <= 24'd0;
         rep_run_q      <= 1'b0;
         idle_cnt_q     <= 28'd0;
         state_q        <= StRun;
         hour_q         <= RST_HOUR;
         minute_q       <= RST_MINUTE;
         second_q       <= 8'h00;
         mode_pulse_q   <= 1'b0;
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         deb_q          <= deb_d;
         press_q        <= press_d;
         deb_mode_cnt_q <= deb_mode_cnt_d;
         deb_inc_cnt_q  <= deb_inc_cnt_d;
         rep_cnt_q      <= rep_cnt_d;
         rep_run_q      <= rep_run_d;
         idle_cnt_q     <= idle_cnt_d;
         state_q        <= state_d;
         hour_q         <= hour_d;
         minute_q       <= minute_d;
         second_q       <= second_d;
         mode_pulse_q   <= mode_pulse_d;
      end
   end

   assign key_b        = state_q;
   assign alarm_hour   = hour_q;
   assign alarm_minute = minute_q;
   assign alarm_second = second_q;
   assign mode_pulse   = mode_pulse_q;

endmodule

// File: tb/tb_alarm_setter.sv
// Directed bench for alarm_setter with a small reference model and a
// scoreboard of expected {key_b, mode_pulse, hour, minute, second} vectors.
module tb_alarm_setter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key_mode;
   logic       key_inc;
   logic [1:0] key_b;
   logic [7:0] alarm_hour;
   logic [7:0] alarm_minute;
   logic [7:0] alarm_second;
   logic       mode_pulse;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state.
   logic [1:0] e_kb;
   logic       e_mp;
   logic [7:0] e_h, e_m, e_s;

   logic [26:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   alarm_setter #(
      .DEB_CYCLES   (20'd4),
      .REPEAT_DELAY (24'd20),
      .REPEAT_PERIOD(24'd5),
      .IDLE_TIMEOUT (28'd100),
      .RST_HOUR     (8'h07),
      .RST_MINUTE   (8'h00)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_mode    (key_mode),
      .key_inc     (key_inc),
      .key_b       (key_b),
      .alarm_hour  (alarm_hour),
      .alarm_minute(alarm_minute),
      .alarm_second(alarm_second),
      .mode_pulse  (mode_pulse)
   );

   // Arithmetic BCD increment: decode to binary, add, wrap, re-encode.
   function automatic logic [7:0] model_bcd_inc(input logic [7:0] v, input int top);
      int b;
      b = int'(v[7:4]) * 10 + int'(v[3:0]);
      b = (b == top) ? 0 : b + 1;
      return {4'(b / 10), 4'(b % 10)};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input string tag);
      exp_q.push_back({e_kb, e_mp, e_h, e_m, e_s});
      tag_q.push_back(tag);
   endtask

   task automatic check();
      logic [26:0] exp_v;
      logic [26:0] obs_v;
      string       tag;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed no entry, required one queued expectation");
         return;
      end
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      obs_v = {key_b, mode_pulse, alarm_hour, alarm_minute, alarm_second};
      assert (obs_v === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed kb=%b mp=%b %h:%h:%h required kb=%b mp=%b %h:%h:%h",
                tag, obs_v[26:25], obs_v[24], obs_v[23:16], obs_v[15:8], obs_v[7:0],
                exp_v[26:25], exp_v[24], exp_v[23:16], exp_v[15:8], exp_v[7:0]);
      end
   endtask

   task automatic press(input logic m, input logic i, input int hold, input int rel);
      if (m) key_mode = 1'b0;
      if (i) key_inc = 1'b0;
      cyc(hold);
      key_mode = 1'b1;
      key_inc  = 1'b1;
      cyc(rel);
   endtask

   task automatic model_inc();
      case (e_kb)
         2'b01:   e_h = model_bcd_inc(e_h, 23);
         2'b10:   e_m = model_bcd_inc(e_m, 59);
         2'b11:   e_s = model_bcd_inc(e_s, 59);
         default: ;
      endcase
   endtask

   task automatic inc_once(input string tag);
      model_inc();
      push(tag);
      press(1'b0, 1'b1, 6, 6);
      check();
   endtask

   task automatic mode_once(input string tag);
      e_kb = e_kb + 2'd1;
      push(tag);
      press(1'b1, 1'b0, 6, 6);
      check();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, required finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      key_mode = 1'b1;
      key_inc  = 1'b1;
      e_kb = 2'b00; e_mp = 1'b0; e_h = 8'h07; e_m = 8'h00; e_s = 8'h00;

      push("reset");
      cyc(3);
      check();
      rst_n = 1'b1;
      push("reset_release");
      cyc(4);
      check();

      // 3-cycle glitch on the mode key is rejected.
      push("glitch");
      press(1'b1, 1'b0, 3, 10);
      check();

      // Mode press: key_b changes exactly 7 cycles after the falling edge.
      key_mode = 1'b0;
      push("mode_pre");
      cyc(6);
      check();
      e_kb = 2'b01; e_mp = 1'b1;
      push("mode_edge");
      cyc(1);
      check();
      e_mp = 1'b0;
      push("mode_pulse_one");
      cyc(1);
      check();
      cyc(2);
      key_mode = 1'b1;
      cyc(8);

      // Hour up to 22, then 23 and wrap to 00.
      while (e_h != 8'h22) inc_once("hour_step");
      inc_once("hour_23");
      inc_once("hour_wrap");

      mode_once("to_set_m");
      while (e_m != 8'h09) inc_once("min_step");
      inc_once("min_09_10");

      mode_once("to_set_s");
      while (e_s != 8'h59) inc_once("sec_step");
      inc_once("sec_wrap");

      mode_once("to_run");
      mode_once("to_set_h2");
      mode_once("to_set_m2");
      while (e_m != 8'h00) inc_once("min_to_00");

      // Held inc: updates at +7, then +27 and every 5 cycles.
      key_inc = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         if (k == 7 || (k >= 27 && (k - 27) % 5 == 0)) e_m = model_bcd_inc(e_m, 59);
         push("repeat");
         cyc(1);
         check();
      end
      key_inc = 1'b1;
      e_m = model_bcd_inc(e_m, 59);
      push("repeat_last");
      cyc(2);
      check();
      push("repeat_stop");
      cyc(20);
      check();

      // Reset while a repeat is in progress in SET_M.
      key_inc = 1'b0;
      cyc(7);
      e_m = model_bcd_inc(e_m, 59);
      push("repeat_mid");
      check();
      cyc(18);
      rst_n   = 1'b0;
      key_inc = 1'b1;
      e_kb = 2'b00; e_h = 8'h07; e_m = 8'h00; e_s = 8'h00;
      push("reset_mid");
      cyc(3);
      check();
      rst_n = 1'b1;
      push("reset_mid_release");
      cyc(10);
      check();

      // Coincident mode and inc presses: mode wins.
      mode_once("to_set_h3");
      e_kb = 2'b10;
      push("simul");
      press(1'b1, 1'b1, 6, 6);
      check();

      // Enter SET_S and let the idle timeout fire.
      key_mode = 1'b0;
      cyc(6);
      key_mode = 1'b1;
      e_kb = 2'b11; e_mp = 1'b1;
      push("to_set_s3");
      cyc(1);
      check();
      e_mp = 1'b0;
      push("timeout_pre");
      cyc(99);
      check();
      e_kb = 2'b00;
      push("timeout");
      cyc(1);
      check();
      push("timeout_no_pulse");
      cyc(1);
      check();

      inc_once("run_inc");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
